// File: rtl/control_unit.sv
// Accumulator-machine control unit: FETCH/EXEC/MEMWAIT/HALT sequencer with registered decode.
// Build option: define CU_BRANCH_EN to decode BEQ/BNE/JMP; otherwise they are illegal NOPs.
module control_unit #(
    parameter int OPCODE  = 5,
    parameter int OPERAND = 11,
    parameter int ALUOP   = 3
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst_n,
    input  logic [OPCODE+OPERAND-1:0] i_Instr,
    input  logic                      i_InstrValid,
    input  logic                      i_MemReady,
    input  logic                      i_AccZero,
    output logic                      o_InstrReq,
    output logic [OPERAND-1:0]        o_Operand,
    output logic                      o_WrPC,
    output logic                      o_WrAcc,
    output logic                      o_WrRam,
    output logic                      o_RdRam,
    output logic                      o_SelB,
    output logic [1:0]                o_SelA,
    output logic [ALUOP-1:0]          o_AluOp,
    output logic                      o_PcSel,
    output logic                      o_Halt,
    output logic                      o_Illegal
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        EXEC    = 2'd1,
        MEMWAIT = 2'd2,
        HALT    = 2'd3
    } state_t;

    state_t state, stateNext;

    logic [OPCODE-1:0]  opc;
    logic [OPERAND-1:0] operandQ;
    logic               wrPcQ, wrAccQ, wrRamQ, rdRamQ, selBQ;
    logic [1:0]         selAQ;
    logic [ALUOP-1:0]   aluOpQ;
    logic               haltQ, illegalQ;

    logic               dWrPc, dWrAcc, dWrRam, dRdRam, dSelB;
    logic [1:0]         dSelA;
    logic [ALUOP-1:0]   dAluOp;
    logic               dHalt, dIllegal;

    logic               accept, memDone, opDone;

`ifdef CU_BRANCH_EN
    logic               beqQ, bneQ, jmpQ;
    logic               dBeq, dBne, dJmp;
`endif

    assign opc     = i_Instr[OPCODE+OPERAND-1:OPERAND];
    assign accept  = (state == FETCH) && i_InstrValid;
    // A memory op is complete only in the cycle the RAM reports ready.
    assign memDone = !(rdRamQ || wrRamQ) || i_MemReady;
    assign opDone  = ((state == EXEC) || (state == MEMWAIT)) && memDone;

    always_comb begin
        dWrPc    = 1'b1;
        dWrAcc   = 1'b0;
        dWrRam   = 1'b0;
        dRdRam   = 1'b0;
        dSelB    = 1'b0;
        dSelA    = 2'b11;
        dAluOp   = '0;
        dHalt    = 1'b0;
        dIllegal = 1'b0;
`ifdef CU_BRANCH_EN
        dBeq     = 1'b0;
        dBne     = 1'b0;
        dJmp     = 1'b0;
`endif
        case (32'(opc))
            32'd0: begin                                  // HLT
                dWrPc = 1'b0;
                dHalt = 1'b1;
            end
            32'd1: dWrRam = 1'b1;                         // STO
            32'd2: begin                                  // LD
                dRdRam = 1'b1;
                dSelA  = 2'b00;
                dWrAcc = 1'b1;
            end
            32'd3: begin                                  // LDI
                dSelA  = 2'b01;
                dWrAcc = 1'b1;
            end
            32'd4, 32'd6, 32'd8, 32'd10, 32'd12: begin    // ADD SUB AND OR XOR
                dSelA  = 2'b10;
                dWrAcc = 1'b1;
                dRdRam = 1'b1;
                dAluOp = ALUOP'((32'(opc) - 32'd4) >> 1);
            end
            32'd5, 32'd7, 32'd9, 32'd11, 32'd13: begin    // immediate forms
                dSelA  = 2'b10;
                dWrAcc = 1'b1;
                dSelB  = 1'b1;
                dAluOp = ALUOP'((32'(opc) - 32'd5) >> 1);
            end
            32'd14: begin                                 // SLL
                dSelA  = 2'b10;
                dWrAcc = 1'b1;
                dSelB  = 1'b1;
                dAluOp = ALUOP'(5);
            end
            32'd15: begin                                 // SRL
                dSelA  = 2'b10;
                dWrAcc = 1'b1;
                dSelB  = 1'b1;
                dAluOp = ALUOP'(6);
            end
`ifdef CU_BRANCH_EN
            32'd16: dBeq = 1'b1;
            32'd17: dBne = 1'b1;
            32'd18: dJmp = 1'b1;
`endif
            default: dIllegal = 1'b1;
        endcase
    end

    always_comb begin
        stateNext = state;
        case (state)
            FETCH:   if (i_InstrValid) stateNext = dHalt ? HALT : EXEC;
            EXEC:    stateNext = memDone ? FETCH : MEMWAIT;
            MEMWAIT: stateNext = memDone ? FETCH : MEMWAIT;
            HALT:    stateNext = HALT;
            default: stateNext = FETCH;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state <= FETCH;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            operandQ <= '0;
            wrPcQ    <= 1'b0;
            wrAccQ   <= 1'b0;
            wrRamQ   <= 1'b0;
            rdRamQ   <= 1'b0;
            selBQ    <= 1'b0;
            selAQ    <= 2'b11;
            aluOpQ   <= '0;
            haltQ    <= 1'b0;
            illegalQ <= 1'b0;
        end else if (accept) begin
            operandQ <= i_Instr[OPERAND-1:0];
            wrPcQ    <= dWrPc;
            wrAccQ   <= dWrAcc;
            wrRamQ   <= dWrRam;
            rdRamQ   <= dRdRam;
            selBQ    <= dSelB;
            selAQ    <= dSelA;
            aluOpQ   <= dAluOp;
            haltQ    <= dHalt;
            illegalQ <= illegalQ | dIllegal;
        end else if (opDone) begin
            wrPcQ    <= 1'b0;
            wrAccQ   <= 1'b0;
            wrRamQ   <= 1'b0;
            rdRamQ   <= 1'b0;
            selBQ    <= 1'b0;
            selAQ    <= 2'b11;
            aluOpQ   <= '0;
        end
    end

`ifdef CU_BRANCH_EN
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            beqQ <= 1'b0;
            bneQ <= 1'b0;
            jmpQ <= 1'b0;
        end else if (accept) begin
            beqQ <= dBeq;
            bneQ <= dBne;
            jmpQ <= dJmp;
        end else if (opDone) begin
            beqQ <= 1'b0;
            bneQ <= 1'b0;
            jmpQ <= 1'b0;
        end
    end

    // Branch condition uses the accumulator flag as seen during EXEC.
    assign o_PcSel = jmpQ || (beqQ && i_AccZero) || (bneQ && !i_AccZero);
`else
    logic unusedAccZero;
    assign unusedAccZero = i_AccZero;
    assign o_PcSel       = 1'b0;
`endif

    assign o_InstrReq = (state == FETCH) && i_Rst_n;
    assign o_Operand  = operandQ;
    assign o_WrPC     = wrPcQ && memDone;
    assign o_WrAcc    = wrAccQ && memDone;
    assign o_WrRam    = wrRamQ;
    assign o_RdRam    = rdRamQ;
    assign o_SelB     = selBQ;
    assign o_SelA     = selAQ;
    assign o_AluOp    = aluOpQ;
    assign o_Halt     = haltQ;
    assign o_Illegal  = illegalQ;

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter OPCODE, default 5: opcode field width, instruction bits [OPCODE+OPERAND-1:OPERAND].
REQ-002 SHALL have parameter OPERAND, default 11: operand field width, instruction bits [OPERAND-1:0].
REQ-003 SHALL have parameter ALUOP, default 3: ALU operation code width, minimum 3.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, exactly as follows.
REQ-005 i_Clk  in  1  clock; all state changes on the rising edge.
REQ-006 i_Rst_n  in  1  asynchronous active-low reset.
REQ-007 i_Instr  in  OPCODE+OPERAND  instruction word from program memory.
REQ-008 i_InstrValid  in  1  i_Instr valid this cycle.
REQ-009 i_MemReady  in  1  data RAM completes the current read/write this cycle.
REQ-010 i_AccZero  in  1  accumulator equals zero.
REQ-011 o_InstrReq  out  1  requesting an instruction.
REQ-012 o_Operand  out  OPERAND  latched operand.
REQ-013 o_WrPC, o_WrAcc, o_WrRam, o_RdRam, o_SelB  out  1 each  datapath strobes and B-mux select.
REQ-014 o_SelA  out  2  accumulator source: 00 RAM, 01 operand, 10 ALU, 11 hold.
REQ-015 o_AluOp  out  ALUOP  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl.
REQ-016 o_PcSel  out  1  0: PC+1, 1: PC<=operand.
REQ-017 o_Halt, o_Illegal  out  1 each  halted; sticky illegal-opcode flag.

Function
REQ-018 SHALL implement FSM states FETCH, EXEC, MEMWAIT, HALT; o_InstrReq=1 only in FETCH.
REQ-019 FETCH with i_InstrValid=1 SHALL latch opcode and operand and go to EXEC; with i_InstrValid=0 it SHALL stay in FETCH with all strobes 0.
REQ-020 All control outputs SHALL be registered and SHALL assert in the cycle the FSM is in EXEC; latency from accepting the instruction to its strobes SHALL be exactly 1 cycle.
REQ-021 Opcodes HLT 00000, STO 00001, LD 00010, LDI 00011, ADD 00100, ADDI 00101, SUB 00110, SUBI 00111 SHALL keep their existing semantics and selects, with o_AluOp 0 for add and 1 for subtract.
REQ-022 SHALL add AND 01000, ANDI 01001, OR 01010, ORI 01011, XOR 01100, XORI 01101, SLL 01110, SRL 01111: SelA=10, WrAcc=1; SelB=1 for the immediate/shift forms; the variable forms RdRam=1, SelB=0.
REQ-023 Branch opcodes: BEQ 10000 (taken if i_AccZero=1), BNE 10001 (taken if i_AccZero=0), JMP 10010 (always taken); o_PcSel=1 when taken; o_WrPC=1 in all three cases.
REQ-024 An opcode with o_RdRam or o_WrRam set, with i_MemReady=0 in EXEC, SHALL move to MEMWAIT; all strobes SHALL be held, with o_WrPC and o_WrAcc forced to 0, until i_MemReady=1; then WrPC and WrAcc assert for exactly 1 cycle.
REQ-025 After a completed EXEC/MEMWAIT cycle the FSM SHALL return to FETCH; non-memory instructions SHALL take 2 cycles and back-to-back issue SHALL be one instruction per 2 cycles.
REQ-026 HLT SHALL set o_Halt=1, enter HALT, keep all strobes 0, and ignore i_InstrValid until reset.
REQ-027 An undefined opcode SHALL execute as a NOP (only o_WrPC=1, PcSel=0) and set o_Illegal, which stays set until reset.
REQ-028 i_AccZero SHALL be sampled in EXEC only.

Reset
REQ-029 On i_Rst_n=0, immediately regardless of clock or state, SHALL set: FSM=FETCH; o_SelA=11; o_Operand=0; o_AluOp=0; every other output 0 except o_InstrReq, which is 1 once in FETCH after deassertion.
REQ-030 Reset during MEMWAIT or HALT SHALL abandon the operation with no strobe issued; the first fetch SHALL occur on the first edge after deassertion.

Configuration
REQ-031 Macro CU_BRANCH_EN: when defined, BEQ/BNE/JMP SHALL decode per REQ-023; when undefined, they SHALL be illegal per REQ-027, and o_PcSel SHALL be constant 0.

Verification
REQ-032 Reset, then LDI 5 valid -> next cycle WrAcc=1, SelA=01, o_Operand=5, WrPC=1; the following cycle o_InstrReq=1.
REQ-033 ADD 3 with i_MemReady=0 for 3 cycles -> RdRam=1 held 4 cycles, WrAcc/WrPC=0 for 3 cycles, then 1 for 1 cycle with SelA=10, AluOp=0.
REQ-034 XORI 0x0F0 -> SelB=1, AluOp=4, WrAcc=1, RdRam=0.
REQ-035 BEQ 0x100 with AccZero=1 -> PcSel=1, WrPC=1; with AccZero=0 -> PcSel=0; with CU_BRANCH_EN undefined -> PcSel=0, o_Illegal=1.
REQ-036 Opcode 11111 -> WrPC=1 only, o_Illegal=1 held; then HLT -> o_Halt=1 and further i_InstrValid ignored; asserting i_Rst_n=0 mid-HALT clears o_Halt and o_Illegal asynchronously.
